imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter ROT_PER_CYCLE, default 1, meaning rotation candidates tested per SEARCH cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, request valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 SHALL have port ImmSrc, input, 2, encoding mode: 00 rotated 8-bit, 01 12-bit unsigned, 10 branch, 11 split 4+4.
REQ-007 SHALL have port Value, input, 32, immediate value to encode.
REQ-008 SHALL have port out_valid, output, 1, result valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port Instr, output, 24, encoded instruction immediate field.
REQ-011 SHALL have port Fits, output, 1, Value is representable in the requested mode.

Function
REQ-012 SHALL implement the FSM states IDLE, SEARCH and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-013 SHALL capture Value and ImmSrc on the in_valid&&in_ready cycle; input changes after capture SHALL be ignored.
REQ-014 Mode 01: Fits = (Value[31:12]==0); Instr = {12'b0, Value[11:0]}.
REQ-015 Mode 10: Fits = (Value[1:0]==0) && Value[31:25] all equal to Value[25]; Instr = Value[25:2].
REQ-016 Mode 11: Fits = (Value[31:8]==0); Instr = {12'b0, Value[7:4], 4'b0, Value[3:0]}.
REQ-017 Mode 00: for rot r in 0..15, W = Value rotated left by 2r; candidate r fits when W[31:8]==0; Instr = {12'b0, r[3:0], W[7:0]} for the smallest fitting r.
REQ-018 Modes 01, 10, 11, and mode 00 with fitting r < ROT_PER_CYCLE, SHALL go IDLE -> DONE; for accept at cycle N, out_valid SHALL be high at N+1.
REQ-019 In all other mode 00 cases the block SHALL go IDLE -> SEARCH and test ROT_PER_CYCLE candidates per cycle in ascending order; it SHALL enter DONE the cycle after the first fit.
REQ-020 With ROT_PER_CYCLE=1, a fit at r SHALL give out_valid at N+1+r.
REQ-021 If no r in 0..15 fits, the block SHALL enter DONE after testing r=15 (N+16 with ROT_PER_CYCLE=1), with Fits=0.
REQ-022 Whenever Fits=0, Instr SHALL be 24'h000000.
REQ-023 All Instr bits not assigned by a mode SHALL be 0.
REQ-024 DONE SHALL hold Instr and Fits stable until out_ready; on out_valid&&out_ready the block SHALL return to IDLE; there is no back-to-back accept, so throughput is at most one result per 2 cycles.
REQ-025 in_valid while not IDLE SHALL have no effect.

Reset
REQ-026 On reset the block SHALL enter IDLE with in_ready=1, out_valid=0, Instr=0 and Fits=0.
REQ-027 Reset during SEARCH or DONE SHALL abandon the request with no result emitted; reset takes priority over all handshakes in the same cycle.

Structure
REQ-028 Package imm_enc_pkg SHALL hold the ImmSrc mode constants (IMM_ROT8, IMM_U12, IMM_BR, IMM_SPLIT), the state enum, and the rotation count constant (16).
REQ-029 The block SHALL contain one combinational sub-module, imm_rot_check, which takes Value and r and returns fit and imm8; the block SHALL instantiate it ROT_PER_CYCLE times.

Verification
REQ-030 Bench SHALL cover: mode 00, Value=0x000000FF -> Instr=0x0000FF, Fits=1, out_valid at N+1.
REQ-031 Bench SHALL cover: mode 00, Value=0xFF000000, ROT_PER_CYCLE=1 -> Instr=0x0004FF, Fits=1, out_valid at N+5.
REQ-032 Bench SHALL cover: mode 00, Value=0x00000102 -> Fits=0, Instr=0, out_valid at N+16.
REQ-033 Bench SHALL cover: mode 10, Value=0xFFFFFFF8 -> Instr=0xFFFFFE, Fits=1; mode 10, Value=0x00000006 -> Fits=0, Instr=0.
REQ-034 Bench SHALL cover: mode 11, Value=0xAB -> Instr=0x000A0B; mode 01, Value=0x1000 -> Fits=0; in both cases, with out_ready held low 3 cycles, outputs stay stable and in_ready stays 0.
REQ-035 Bench SHALL cover: reset asserted at N+3 of a mode 00 0xFF000000 search -> next cycle IDLE, out_valid=0, and no result ever appears.

Source files
------------

// File: rtl/imm_enc_pkg.sv
// -----------------------------------------------------------------------------
// imm_enc_pkg
// Shared definitions for the immediate encoder:
//   - ImmSrc mode constants (IMM_ROT8, IMM_U12, IMM_BR, IMM_SPLIT)
//   - controller state enum (IDLE, SEARCH, DONE)
//   - rotation candidate count (ROT_COUNT = 16)
//   - encode_direct(): single-step encoding for the non-rotated modes
// -----------------------------------------------------------------------------
package imm_enc_pkg;

    // Encoding modes carried on ImmSrc
    localparam logic [1:0] IMM_ROT8  = 2'b00;
    localparam logic [1:0] IMM_U12   = 2'b01;
    localparam logic [1:0] IMM_BR    = 2'b10;
    localparam logic [1:0] IMM_SPLIT = 2'b11;

    // Number of even rotations (0, 2, ..., 30) tried in rotated mode
    localparam int ROT_COUNT = 16;

    // Controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Encoded result: representable flag plus 24-bit immediate field
    typedef struct packed {
        logic        fits;
        logic [23:0] instr;
    } enc_t;

    // Encodes the modes that need no search. The rotated mode is handled by
    // the rotation checkers, so it returns an all-zero result here. The
    // field is forced to zero whenever the value does not fit, so a
    // non-representable value never leaks partial bits to the consumer.
    function automatic enc_t encode_direct(input logic [1:0]  mode,
                                           input logic [31:0] value);
        enc_t res;
        res.fits  = 1'b0;
        res.instr = 24'h000000;
        case (mode)
            IMM_U12: begin
                res.fits  = (value[31:12] == 20'h00000);
                res.instr = {12'h000, value[11:0]};
            end
            IMM_BR: begin
                // word aligned, and bits 31:25 a sign extension of bit 25
                res.fits  = (value[1:0] == 2'b00) &&
                            ((value[31:25] == 7'h00) || (value[31:25] == 7'h7F));
                res.instr = value[25:2];
            end
            IMM_SPLIT: begin
                res.fits  = (value[31:8] == 24'h000000);
                res.instr = {12'h000, value[7:4], 4'h0, value[3:0]};
            end
            default: begin
                res.fits  = 1'b0;
                res.instr = 24'h000000;
            end
        endcase
        if (!res.fits) begin
            res.instr = 24'h000000;
        end else begin
            res.instr = res.instr;
        end
        return res;
    endfunction

endpackage

// File: rtl/imm_rot_check.sv
// -----------------------------------------------------------------------------
// imm_rot_check
// Purely combinational test of one rotation candidate: the value is rotated
// left by 2*rot and the candidate fits when everything above bit 7 is zero.
// Ports:
//   value [31:0]  value under test
//   rot   [3:0]   rotation index r (rotation amount is 2*r)
//   fit           candidate r represents value
//   imm8  [7:0]   low byte of the rotated value (the 8-bit immediate)
// -----------------------------------------------------------------------------
module imm_rot_check
    import imm_enc_pkg::*;
(
    input  logic [31:0] value,
    input  logic [3:0]  rot,
    output logic        fit,
    output logic [7:0]  imm8
);

    logic [4:0]  shamt_s;
    logic [63:0] dbl_s;
    logic [31:0] rotated_s;

    // Rotate-left built from a doubled word: shifting {v,v} left and keeping
    // the upper half avoids a 32-bit shift by 32 when rot is zero.
    always_comb begin
        shamt_s   = {rot, 1'b0};
        dbl_s     = {value, value} << shamt_s;
        rotated_s = dbl_s[63:32];
        fit       = (rotated_s[31:8] == 24'h000000);
        imm8      = rotated_s[7:0];
    end

endmodule

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
// Encodes a 32-bit immediate into a 24-bit instruction field in one of four
// modes. Non-rotated modes resolve in a single cycle; the rotated 8-bit mode
// searches rotations 0..15 in ascending order, ROT_PER_CYCLE per cycle
// (1, 2 or 4; must divide ROT_COUNT), and reports the smallest fitting one.
//
// Parameters:
//   ROT_PER_CYCLE  rotation candidates tested per cycle (1, 2 or 4)
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous active-high reset
//   in_valid       request valid
//   in_ready       block is IDLE and can accept a request
//   ImmSrc [1:0]   mode: 00 rot8, 01 u12, 10 branch, 11 split 4+4
//   Value  [31:0]  immediate to encode
//   out_valid      result valid (DONE state)
//   out_ready      consumer accepts result
//   Instr  [23:0]  encoded immediate field (zero when Fits=0)
//   Fits           Value is representable in the requested mode
// -----------------------------------------------------------------------------
module imm_encoder
    import imm_enc_pkg::*;
#(
    parameter int ROT_PER_CYCLE = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  ImmSrc,
    input  logic [31:0] Value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] Instr,
    output logic        Fits
);

    // Search steps by ROT_PER_CYCLE; the last chunk starts at LAST_BASE
    localparam logic [3:0] STEP      = 4'(ROT_PER_CYCLE);
    localparam logic [3:0] LAST_BASE = 4'(ROT_COUNT - ROT_PER_CYCLE);

    state_t      state_r;
    state_t      state_nxt_s;

    logic [31:0] value_r;
    logic [3:0]  base_r;
    logic [23:0] instr_r;
    logic        fits_r;

    logic        accept_s;
    logic [31:0] cand_value_s;
    logic [3:0]  cand_base_s;
    logic        last_chunk_s;

    logic [3:0]  rot_s  [ROT_PER_CYCLE];
    logic        fit_s  [ROT_PER_CYCLE];
    logic [7:0]  imm8_s [ROT_PER_CYCLE];

    logic        hit_s;
    logic [3:0]  hit_rot_s;
    logic [7:0]  hit_imm_s;

    enc_t        direct_s;
    logic        load_s;
    enc_t        res_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign Instr     = instr_r;
    assign Fits      = fits_r;

    assign accept_s  = in_valid && (state_r == IDLE);

    // Candidate source: on the accept cycle the first chunk is tested
    // directly on the incoming value so an early fit costs no extra cycle;
    // during SEARCH the captured value is used so later input changes are
    // ignored.
    always_comb begin
        if (state_r == IDLE) begin
            cand_value_s = Value;
            cand_base_s  = 4'd0;
            last_chunk_s = 1'b0;
        end else begin
            cand_value_s = value_r;
            cand_base_s  = base_r;
            last_chunk_s = (base_r == LAST_BASE);
        end
    end

    genvar g;
    generate
        for (g = 0; g < ROT_PER_CYCLE; g++) begin : g_rot
            assign rot_s[g] = cand_base_s + 4'(g);

            imm_rot_check u_rot_check (
                .value (cand_value_s),
                .rot   (rot_s[g]),
                .fit   (fit_s[g]),
                .imm8  (imm8_s[g])
            );
        end
    endgenerate

    // Priority pick: walk from the highest lane down so the lowest fitting
    // rotation is the one left standing.
    always_comb begin
        hit_s     = 1'b0;
        hit_rot_s = 4'd0;
        hit_imm_s = 8'h00;
        for (int i = ROT_PER_CYCLE - 1; i >= 0; i--) begin
            hit_s     = fit_s[i] ? 1'b1      : hit_s;
            hit_rot_s = fit_s[i] ? rot_s[i]  : hit_rot_s;
            hit_imm_s = fit_s[i] ? imm8_s[i] : hit_imm_s;
        end
    end

    // Next-state logic for the IDLE / SEARCH / DONE controller
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (ImmSrc != IMM_ROT8) begin
                        state_nxt_s = DONE;
                    end else if (hit_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = SEARCH;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEARCH: begin
                if (hit_s || last_chunk_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SEARCH;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Result selection: direct modes on accept, otherwise the rotation hit,
    // otherwise an all-zero "does not fit" result after the last chunk.
    always_comb begin
        direct_s = encode_direct(ImmSrc, Value);
        load_s   = (state_nxt_s == DONE) && (state_r != DONE);
        if ((state_r == IDLE) && (ImmSrc != IMM_ROT8)) begin
            res_s = direct_s;
        end else if (hit_s) begin
            res_s.fits  = 1'b1;
            res_s.instr = {12'h000, hit_rot_s, hit_imm_s};
        end else begin
            res_s.fits  = 1'b0;
            res_s.instr = 24'h000000;
        end
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request capture and search position
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r <= 32'h00000000;
            base_r  <= 4'd0;
        end else if (accept_s) begin
            value_r <= Value;
            base_r  <= STEP;
        end else if (state_r == SEARCH) begin
            value_r <= value_r;
            base_r  <= base_r + STEP;
        end else begin
            value_r <= value_r;
            base_r  <= base_r;
        end
    end

    // Result registers, held stable through DONE until the handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_r <= 24'h000000;
            fits_r  <= 1'b0;
        end else if (load_s) begin
            instr_r <= res_s.instr;
            fits_r  <= res_s.fits;
        end else begin
            instr_r <= instr_r;
            fits_r  <= fits_r;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
// Directed self-checking bench for imm_encoder (ROT_PER_CYCLE = 1).
// Expected results are pushed to a scoreboard queue when a request is driven
// and popped when out_valid appears.
// -----------------------------------------------------------------------------
module tb_imm_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ImmSrc;
    logic [31:0] Value;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] Instr;
    logic        Fits;

    typedef struct {
        logic [23:0] instr;
        logic        fits;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_err;

    imm_encoder #(.ROT_PER_CYCLE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ImmSrc    (ImmSrc),
        .Value     (Value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Instr     (Instr),
        .Fits      (Fits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request: drive, wait for result, check latency/value, optionally
    // stall the consumer for 'hold' cycles, then complete the handshake.
    task automatic run_req(input string tag, input logic [1:0] mode, input logic [31:0] val,
                           input logic [23:0] e_instr, input logic e_fits, input int e_lat,
                           input int hold);
        exp_t e;
        int   cnt;
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        ImmSrc   = mode;
        Value    = val;
        in_valid = 1'b1;
        sb_q.push_back('{instr: e_instr, fits: e_fits, lat: e_lat});
        @(posedge clk); #1;
        // garbage on the inputs after capture must be ignored
        ImmSrc = ~mode;
        Value  = 32'hDEADBEEF;
        cnt = 1;
        while (out_valid !== 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        in_valid = 1'b0;
        e = sb_q.pop_front();
        chk({tag, ".latency"}, 32'(cnt), 32'(e.lat));
        chk({tag, ".instr"}, 32'(Instr), 32'(e.instr));
        chk({tag, ".fits"}, 32'(Fits), 32'(e.fits));
        chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_instr"}, 32'(Instr), 32'(e.instr));
            chk({tag, ".hold_fits"}, 32'(Fits), 32'(e.fits));
            chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ImmSrc    = 2'b00;
        Value     = 32'h00000000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.instr", 32'(Instr), 32'd0);
        chk("reset.fits", 32'(Fits), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // rotated mode
        run_req("rot_ff",       2'b00, 32'h000000FF, 24'h0000FF, 1'b1, 1,  0);
        run_req("rot_ff000000", 2'b00, 32'hFF000000, 24'h0004FF, 1'b1, 5,  0);
        run_req("rot_102",      2'b00, 32'h00000102, 24'h000000, 1'b0, 16, 0);
        run_req("rot_c000003f", 2'b00, 32'hC000003F, 24'h0001FF, 1'b1, 2,  0);
        run_req("rot_3fc",      2'b00, 32'h000003FC, 24'h000FFF, 1'b1, 16, 0);
        run_req("rot_zero",     2'b00, 32'h00000000, 24'h000000, 1'b1, 1,  0);
        // branch mode
        run_req("br_neg",       2'b10, 32'hFFFFFFF8, 24'hFFFFFE, 1'b1, 1,  0);
        run_req("br_unaligned", 2'b10, 32'h00000006, 24'h000000, 1'b0, 1,  0);
        run_req("br_maxpos",    2'b10, 32'h01FFFFFC, 24'h7FFFFF, 1'b1, 1,  0);
        run_req("br_badsign",   2'b10, 32'h02000000, 24'h000000, 1'b0, 1,  0);
        // split and unsigned modes, with consumer back-pressure
        run_req("split_ab",     2'b11, 32'h000000AB, 24'h000A0B, 1'b1, 1,  3);
        run_req("u12_1000",     2'b01, 32'h00001000, 24'h000000, 1'b0, 1,  3);
        run_req("u12_fff",      2'b01, 32'h00000FFF, 24'h000FFF, 1'b1, 1,  0);
        run_req("split_100",    2'b11, 32'h00000100, 24'h000000, 1'b0, 1,  0);

        // reset in the middle of a search abandons the request
        chk("rst_mid.in_ready_idle", 32'(in_ready), 32'd1);
        ImmSrc   = 2'b00;
        Value    = 32'hFF000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid.instr", 32'(Instr), 32'd0);
        chk("rst_mid.fits", 32'(Fits), 32'd0);
        reset = 1'b0;
        seen  = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1;
        end
        chk("rst_mid.no_result", 32'(seen), 32'd0);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
